lif_neuron_array: RTL
=====================

# lif_neuron_array

Parametrised multi-channel leaky integrate-and-fire (LIF) neuron core, successor to the single-channel integrate-and-fire tile. Each of N_CH channels integrates an unsigned input current into a membrane potential with shift-based leak, fires a one-cycle spike at a shared threshold, then enters a fixed refractory period. The block sits directly behind the tile I/O: per-channel currents come in on a packed bus, spikes and one selected membrane state go out.

## Interface
- WIDTH, 8: membrane/current/threshold width in bits (unsigned), ≥4
- N_CH, 4: number of neuron channels, ≥1
- LEAK_SHIFT, 3: leak = v >> LEAK_SHIFT per update; 0 disables leak
- REFRACT, 2: refractory cycles after a spike, 0..15
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous assert, active low
- ena  in  1  update enable; low = hold all state
- cur_in  in  N_CH*WIDTH  channel i current at [i*WIDTH +: WIDTH]
- threshold  in  WIDTH  shared firing threshold
- sel  in  max(1,$clog2(N_CH))  channel whose membrane appears on state_out
- state_out  out  WIDTH  membrane v[sel], combinational mux of registered v
- spike  out  N_CH  registered one-cycle spike pulse per channel
- spike_cnt  out  16  saturating total spike count, all channels

## Operation
- Per channel: registers v[WIDTH], refr[4], spike bit.
- v_next = min(v − (v >> LEAK_SHIFT) + I, 2^WIDTH − 1); sum computed in WIDTH+1 bits, then clamped.
- On each rising edge with ena=1, per channel, priority order:
  - refr ≠ 0: v ← 0, refr ← refr − 1, spike ← 0 (input ignored).
  - else v_next ≥ threshold: spike ← 1, v ← reset value, refr ← REFRACT.
  - else: v ← v_next, spike ← 0.
- Reset value of v after fire: 0 (hard reset) unless LIF_SOFT_RESET_EN.
- threshold = 0: every enabled non-refractory cycle fires.
- ena=0: v, refr, spike_cnt hold; spike ← 0 on that edge.
- spike_cnt ← min(spike_cnt + popcount(spikes firing this edge), 65535); simultaneous spikes on several channels all counted in one cycle.
- sel ≥ N_CH: state_out = 0.
- threshold and cur_in sampled on the updating edge only; changes mid-run take effect next update.

## Timing
- Reset (rst_n=0, asynchronous): v=0, refr=0, spike=0, spike_cnt=0 immediately; state_out=0.
- Release of rst_n synchronous to clk at integration level; first update on first rising edge with rst_n=1, ena=1.
- Latency: current sampled at edge k is reflected in v and spike after edge k (visible in cycle k+1); one-cycle pulse width.
- Refractory: after firing at edge k, edges k+1..k+REFRACT (enabled) force v=0; integration resumes at edge k+REFRACT+1. Disabled edges do not consume refractory count.
- Asserting rst_n mid-refractory or mid-integration clears all channels; no spike pending afterwards.
- state_out follows sel combinationally within the same cycle.

## Configuration
- LIF_SOFT_RESET_EN defined: on fire, v ← v_next − threshold (residual retained; never negative since v_next ≥ threshold).
- Undefined: on fire, v ← 0.
- All other behaviour identical in both builds.

## Test plan
Defaults WIDTH=8, N_CH=4, LEAK_SHIFT=3, REFRACT=2, ena=1 unless stated.
- Reset: drive arbitrary inputs, pulse rst_n low between edges -> v all 0, spike=0000, spike_cnt=0, state_out=0 without a clock edge.
- Integrate/fire ch0: I=40, threshold=100, sel=0 -> state_out 40, 75, then spike[0]=1 with v=0 on third edge (soft reset build: v=6); two edges at v=0 regardless of input, then 40.
- Leak: ch1 I=40 for two edges (v=75), then I=0 -> v 66, 58, 51; no spike.
- Saturation/simultaneous: all channels I=200, threshold=255 -> v=200 then clamp 255 ≥ 255, spike=1111 on second edge, spike_cnt=4.
- Hold: ch0 at v=75, drop ena for 3 edges -> v stays 75, spike=0, spike_cnt unchanged; refractory count frozen when ena drops right after a spike.
- Counter saturation: threshold=0, all channels fire, preload by running until spike_cnt reaches 65535 -> stays 65535; async reset mid-refractory -> all counters and v zero, next enabled edge integrates normally.

Source files
------------

// File: rtl/lif_neuron_array_if.sv
// Bus bundle for lif_neuron_array: per-channel currents, shared threshold,
// update enable and membrane-select in; spikes, counter and selected state out.
interface lif_neuron_array_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic                    ena;
  logic [N_CH*WIDTH-1:0]   cur_in;
  logic [WIDTH-1:0]        threshold;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        state_out;
  logic [N_CH-1:0]         spike;
  logic [15:0]             spike_cnt;

  modport master (
    output ena, cur_in, threshold, sel,
    input  state_out, spike, spike_cnt
  );

  modport slave (
    input  ena, cur_in, threshold, sel,
    output state_out, spike, spike_cnt
  );
endinterface

// File: rtl/lif_neuron_array.sv
// Multi-channel leaky integrate-and-fire neuron core.
// Each channel integrates an unsigned current with shift-based leak, fires a
// one-cycle spike at a shared threshold and then sits out a fixed refractory
// period. A saturating 16-bit counter totals spikes over all channels.
// Optional build macro: LIF_SOFT_RESET_EN -- on fire keep the residual
// (v_next - threshold) instead of clearing the membrane to zero.
module lif_neuron_array #(
  parameter int WIDTH      = 8,
  parameter int N_CH       = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 2
) (
  input logic               clk,
  input logic               rst_n,
  lif_neuron_array_if.slave bus
);

  localparam int         SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam bit         LEAK_EN   = (LEAK_SHIFT > 0);
  localparam logic [3:0] REFRACT_V = 4'(REFRACT);

  // Per-channel state
  logic [WIDTH-1:0] v_r     [N_CH];
  logic [3:0]       refr_r  [N_CH];
  logic [N_CH-1:0]  spike_r;
  logic [15:0]      cnt_r;

  // Per-channel next-state terms
  logic [WIDTH-1:0] cur_s     [N_CH];
  logic [WIDTH-1:0] leak_s    [N_CH];
  logic [WIDTH:0]   sum_s     [N_CH];
  logic [WIDTH-1:0] integ_s   [N_CH];
  logic [WIDTH-1:0] v_nxt_s   [N_CH];
  logic [3:0]       refr_nxt_s[N_CH];
  logic [N_CH-1:0]  spike_nxt_s;
  logic [16:0]      cnt_sum_s;
  logic [15:0]      cnt_nxt_s;
  logic [WIDTH-1:0] state_s;

  // Number of set bits in a spike vector
  function automatic logic [15:0] popcount(input logic [N_CH-1:0] bits);
    logic [15:0] acc;
    acc = 16'd0;
    for (int k = 0; k < N_CH; k++) begin
      acc = acc + {15'd0, bits[k]};
    end
    return acc;
  endfunction

  // Leak, clamped integration and refractory/fire priority per channel
  always_comb begin
    spike_nxt_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      cur_s[i] = bus.cur_in[i*WIDTH +: WIDTH];
      if (LEAK_EN) begin
        leak_s[i] = v_r[i] >> LEAK_SHIFT;
      end else begin
        leak_s[i] = {WIDTH{1'b0}};
      end
      // Leak never exceeds v, so the difference cannot wrap; only the
      // addition of the current needs the extra carry bit.
      sum_s[i] = {1'b0, v_r[i] - leak_s[i]} + {1'b0, cur_s[i]};
      if (sum_s[i][WIDTH]) begin
        integ_s[i] = {WIDTH{1'b1}};
      end else begin
        integ_s[i] = sum_s[i][WIDTH-1:0];
      end

      if (!bus.ena) begin
        v_nxt_s[i]    = v_r[i];
        refr_nxt_s[i] = refr_r[i];
      end else if (refr_r[i] != 4'd0) begin
        v_nxt_s[i]    = {WIDTH{1'b0}};
        refr_nxt_s[i] = refr_r[i] - 4'd1;
      end else if (integ_s[i] >= bus.threshold) begin
        spike_nxt_s[i] = 1'b1;
`ifdef LIF_SOFT_RESET_EN
        v_nxt_s[i]     = integ_s[i] - bus.threshold;
`else
        v_nxt_s[i]     = {WIDTH{1'b0}};
`endif
        refr_nxt_s[i]  = REFRACT_V;
      end else begin
        v_nxt_s[i]    = integ_s[i];
        refr_nxt_s[i] = refr_r[i];
      end
    end
  end

  // Saturating spike total; every channel firing this edge counts at once
  always_comb begin
    cnt_sum_s = {1'b0, cnt_r} + {1'b0, popcount(spike_nxt_s)};
    if (cnt_sum_s[16]) begin
      cnt_nxt_s = 16'hFFFF;
    end else begin
      cnt_nxt_s = cnt_sum_s[15:0];
    end
  end

  // Membrane, refractory, spike and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        v_r[i]    <= {WIDTH{1'b0}};
        refr_r[i] <= 4'd0;
      end
      spike_r <= {N_CH{1'b0}};
      cnt_r   <= 16'd0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        v_r[i]    <= v_nxt_s[i];
        refr_r[i] <= refr_nxt_s[i];
      end
      spike_r <= spike_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Selected membrane readout; an out-of-range select matches nothing and reads 0
  always_comb begin
    state_s = {WIDTH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      state_s = state_s | ((bus.sel == SEL_W'(i)) ? v_r[i] : {WIDTH{1'b0}});
    end
  end

  assign bus.state_out = state_s;
  assign bus.spike     = spike_r;
  assign bus.spike_cnt = cnt_r;

endmodule
